ovc_alloc_credit_tracker: RTL and testbench

- Per-output-port stage that sits directly downstream of the class/priority candidate-OVC logic.
- Consumes each requesting input VC's candidate OVC mask and destination-based priority mask.
- Arbitrates among requesters, allocates one free output VC per cycle, and tracks per-OVC ownership and downstream credits until the packet tail departs.

---
 rtl/ovc_alloc_credit_tracker.sv | 155 +++++++++++++++
 tb/tb_ovc_alloc_credit_tracker.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ovc_alloc_credit_tracker.sv
// Output-VC allocator and per-OVC credit tracker for one output port.
// Latency: request seen in cycle t -> grant/grant_ovc/allocation registered at the next edge.
// Backpressure: requesters hold req until granted; an OVC is only handed out when free.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   req                 per-requester OVC request (R bits)
//   cand_ovcs/prio_ovcs candidate / preferred OVC masks, V bits per requester
//   grant, grant_ovc    registered one-hot grant pulse and the OVC it carries
//   flit_sent_ovc       one-hot OVC a flit departed on this cycle (qualifies tail_sent)
//   tail_sent           departing flit is a tail; releases that OVC
//   credit_in           per-OVC credit return
//   ovc_free            OVC not allocated
//   ovc_credit_avail    per-OVC credit counter nonzero
//   credit_err          sticky protocol-error flag, cleared only by reset
module ovc_alloc_credit_tracker #(
  parameter int V = 4,
  parameter int R = 4,
  parameter int B = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [R-1:0]   req,
  input  logic [R*V-1:0] cand_ovcs,
  input  logic [R*V-1:0] prio_ovcs,
  output logic [R-1:0]   grant,
  output logic [V-1:0]   grant_ovc,
  input  logic [V-1:0]   flit_sent_ovc,
  input  logic           tail_sent,
  input  logic [V-1:0]   credit_in,
  output logic [V-1:0]   ovc_free,
  output logic [V-1:0]   ovc_credit_avail,
  output logic           credit_err
);

  localparam int BW = $clog2(B + 1);
  localparam int PW = (R > 1) ? $clog2(R) : 1;

  logic [V-1:0]  allocated;
  logic [PW-1:0] rr_ptr;
  logic [BW-1:0] cnt [V];
  logic [BW-1:0] cnt_nxt [V];

  logic [R-1:0]  elig;
  logic          win_vld;
  logic [R-1:0]  win_oh;
  logic [PW-1:0] win_idx;
  logic [V-1:0]  cand_w;
  logic [V-1:0]  prio_w;
  logic [V-1:0]  pick;
  logic [V-1:0]  alloc_oh;

  logic          sent_any;
  logic          sent_single;
  logic          sent_multi;
  logic [V-1:0]  send_vec;
  logic [V-1:0]  release_vec;
  logic          unalloc_err;
  logic          cnt_err;

  assign ovc_free = ~allocated;

  always_comb begin
    for (int i = 0; i < V; i++) begin
      ovc_credit_avail[i] = (cnt[i] != '0);
    end
  end

  // Only requesters that could actually be served take part in arbitration.
  always_comb begin
    for (int r = 0; r < R; r++) begin
      elig[r] = req[r] & (|(cand_ovcs[r*V +: V] & ovc_free));
    end
  end

  // Round-robin search from rr_ptr upward; scanning offsets high-to-low
  // leaves the nearest eligible requester as the final winner.
  always_comb begin
    win_vld = 1'b0;
    win_oh  = '0;
    win_idx = '0;
    for (int k = R - 1; k >= 0; k--) begin
      if (elig[(int'(rr_ptr) + k) % R]) begin
        win_vld = 1'b1;
        win_idx = PW'((int'(rr_ptr) + k) % R);
        win_oh  = R'(1) << ((int'(rr_ptr) + k) % R);
      end
    end
  end

  always_comb begin
    cand_w = '0;
    prio_w = '0;
    for (int r = 0; r < R; r++) begin
      if (win_oh[r]) begin
        cand_w = cand_ovcs[r*V +: V];
        prio_w = prio_ovcs[r*V +: V];
      end
    end
  end

  // Preferred free candidates first, otherwise any free candidate; lowest index wins.
  always_comb begin
    pick = (|(cand_w & prio_w & ovc_free)) ? (cand_w & prio_w & ovc_free)
                                           : (cand_w & ovc_free);
    alloc_oh = win_vld ? (pick & (~pick + {{(V-1){1'b0}}, 1'b1})) : '0;
  end

  // Multi-hot departures are flagged and otherwise ignored entirely.
  always_comb begin
    sent_any    = |flit_sent_ovc;
    sent_single = sent_any && ((flit_sent_ovc & (flit_sent_ovc - {{(V-1){1'b0}}, 1'b1})) == '0);
    sent_multi  = sent_any && !sent_single;
    send_vec    = sent_single ? flit_sent_ovc : '0;
    release_vec = (sent_single && tail_sent) ? flit_sent_ovc : '0;
    unalloc_err = |(send_vec & ~allocated);
  end

  // Send and credit on the same OVC cancel; saturating ends raise an error.
  always_comb begin
    cnt_err = 1'b0;
    for (int i = 0; i < V; i++) begin
      cnt_nxt[i] = cnt[i];
      if (send_vec[i] && !credit_in[i]) begin
        if (cnt[i] == '0) cnt_err = 1'b1;
        else              cnt_nxt[i] = cnt[i] - 1'b1;
      end else if (!send_vec[i] && credit_in[i]) begin
        if (cnt[i] == BW'(B)) cnt_err = 1'b1;
        else                  cnt_nxt[i] = cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant      <= '0;
      grant_ovc  <= '0;
      allocated  <= '0;
      rr_ptr     <= '0;
      credit_err <= 1'b0;
      for (int i = 0; i < V; i++) cnt[i] <= BW'(B);
    end else begin
      grant     <= win_oh;
      grant_ovc <= alloc_oh;
      // Released and newly allocated OVCs are always distinct.
      allocated <= (allocated & ~release_vec) | alloc_oh;
      if (win_vld) begin
        rr_ptr <= (int'(win_idx) == R - 1) ? '0 : win_idx + 1'b1;
      end
      if (sent_multi || unalloc_err || cnt_err) credit_err <= 1'b1;
      for (int i = 0; i < V; i++) cnt[i] <= cnt_nxt[i];
    end
  end

endmodule

// File: tb/tb_ovc_alloc_credit_tracker.sv
module tb_ovc_alloc_credit_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] cand_ovcs;
  logic [15:0] prio_ovcs;
  logic [3:0]  grant;
  logic [3:0]  grant_ovc;
  logic [3:0]  flit_sent_ovc;
  logic        tail_sent;
  logic [3:0]  credit_in;
  logic [3:0]  ovc_free;
  logic [3:0]  ovc_credit_avail;
  logic        credit_err;

  int checks = 0;
  int errors = 0;

  ovc_alloc_credit_tracker #(.V(4), .R(4), .B(4)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .cand_ovcs(cand_ovcs),
    .prio_ovcs(prio_ovcs),
    .grant(grant),
    .grant_ovc(grant_ovc),
    .flit_sent_ovc(flit_sent_ovc),
    .tail_sent(tail_sent),
    .credit_in(credit_in),
    .ovc_free(ovc_free),
    .ovc_credit_avail(ovc_credit_avail),
    .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req = '0; cand_ovcs = '0; prio_ovcs = '0;
    flit_sent_ovc = '0; tail_sent = 1'b0; credit_in = '0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    do_reset();

    // Reset then idle
    for (int c = 0; c < 10; c++) begin
      chk("idle_free", 32'(ovc_free), 32'hF);
      chk("idle_avail", 32'(ovc_credit_avail), 32'hF);
      chk("idle_grant", 32'(grant), 32'h0);
      chk("idle_err", 32'(credit_err), 32'h0);
      tick();
    end

    // Single request with preferred OVC
    req = 4'b0001; cand_ovcs = 16'h000C; prio_ovcs = 16'h0008;
    tick();
    chk("single_grant", 32'(grant), 32'h1);
    chk("single_ovc", 32'(grant_ovc), 32'h8);
    req = '0;
    tick();
    chk("single_pulse", 32'(grant), 32'h0);
    chk("single_ovc_pulse", 32'(grant_ovc), 32'h0);
    chk("single_free", 32'(ovc_free), 32'h7);
    chk("single_err", 32'(credit_err), 32'h0);

    // Credit return on a full counter
    credit_in = 4'b0100;
    tick();
    credit_in = '0;
    chk("ovf_err", 32'(credit_err), 32'h1);
    chk("ovf_avail", 32'(ovc_credit_avail), 32'hF);

    // Priority fallback and fairness (r3 takes OVC3, pointer back at 0)
    do_reset();
    chk("rst_err_clear", 32'(credit_err), 32'h0);
    req = 4'b1000; cand_ovcs = 16'h8000; prio_ovcs = '0;
    tick();
    chk("r3_grant", 32'(grant), 32'h8);
    chk("r3_ovc", 32'(grant_ovc), 32'h8);
    req = 4'b0101; cand_ovcs = 16'h0C0C; prio_ovcs = 16'h0808;
    tick();
    chk("fb_grant", 32'(grant), 32'h1);
    chk("fb_ovc", 32'(grant_ovc), 32'h4);
    req = 4'b0100;
    tick();
    chk("fb_r2_blocked", 32'(grant), 32'h0);
    chk("fb_free", 32'(ovc_free), 32'h3);
    flit_sent_ovc = 4'b1000; tail_sent = 1'b1;
    tick();
    flit_sent_ovc = '0; tail_sent = 1'b0;
    chk("tail_no_bypass", 32'(grant), 32'h0);
    chk("tail_free", 32'(ovc_free), 32'hB);
    tick();
    chk("fb_r2_grant", 32'(grant), 32'h4);
    chk("fb_r2_ovc", 32'(grant_ovc), 32'h8);
    req = '0;
    tick();
    chk("fb_err", 32'(credit_err), 32'h0);
    chk("fb_free_end", 32'(ovc_free), 32'h3);

    // Round-robin over four continuously eligible requesters
    do_reset();
    req = 4'b1111; cand_ovcs = 16'hFFFF; prio_ovcs = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_grant", 32'(grant), 32'(1 << i));
      chk("rr_ovc", 32'(grant_ovc), 32'(1 << i));
      req[i] = 1'b0;
    end
    tick();
    chk("rr_done", 32'(grant), 32'h0);
    chk("rr_free", 32'(ovc_free), 32'h0);

    // Multi-hot departure: flagged, no release
    flit_sent_ovc = 4'b0011; tail_sent = 1'b1;
    tick();
    flit_sent_ovc = '0; tail_sent = 1'b0;
    chk("multi_err", 32'(credit_err), 32'h1);
    chk("multi_free", 32'(ovc_free), 32'h0);
    chk("multi_avail", 32'(ovc_credit_avail), 32'hF);

    // Credits on OVC1
    do_reset();
    req = 4'b0010; cand_ovcs = 16'h0020; prio_ovcs = '0;
    tick();
    chk("c_grant_ovc", 32'(grant_ovc), 32'h2);
    req = '0;
    for (int s = 1; s <= 4; s++) begin
      flit_sent_ovc = 4'b0010;
      tick();
      chk("c_avail", 32'(ovc_credit_avail), (s == 4) ? 32'hD : 32'hF);
      chk("c_err_clean", 32'(credit_err), 32'h0);
    end
    tick();
    chk("c_underflow_err", 32'(credit_err), 32'h1);
    chk("c_underflow_avail", 32'(ovc_credit_avail), 32'hD);
    flit_sent_ovc = '0; credit_in = 4'b0010;
    tick();
    chk("c_return", 32'(ovc_credit_avail), 32'hF);
    flit_sent_ovc = 4'b0010;
    tick();
    chk("c_both", 32'(ovc_credit_avail), 32'hF);
    credit_in = '0;
    tick();
    flit_sent_ovc = '0;
    chk("c_back_to_zero", 32'(ovc_credit_avail), 32'hD);
    chk("c_still_alloc", 32'(ovc_free), 32'hD);

    // Reset mid-grant
    req = 4'b0001; cand_ovcs = 16'h0001;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mr_free_async", 32'(ovc_free), 32'hF);
    tick();
    chk("mr_grant", 32'(grant), 32'h0);
    chk("mr_grant_ovc", 32'(grant_ovc), 32'h0);
    chk("mr_free", 32'(ovc_free), 32'hF);
    chk("mr_avail", 32'(ovc_credit_avail), 32'hF);
    chk("mr_err", 32'(credit_err), 32'h0);
    req = '0;
    reset = 1'b1;
    tick();
    chk("mr_post_grant", 32'(grant), 32'h0);
    chk("mr_post_free", 32'(ovc_free), 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
